// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   DM_DEPTH   default number of 32-bit words of storage
//   DM_DATA_W  storage word width
//   dm_state_e controller states (CLEAR while zeroing storage, READY after)
//   dm_merge   bit-masked write merge used by the storage array
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam int DM_DEPTH  = 1024;
    localparam int DM_DATA_W = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_e;

    // Keep old bits where wmask is 0, take new bits where wmask is 1.
    function automatic logic [DM_DATA_W-1:0] dm_merge(
        input logic [DM_DATA_W-1:0] old_word,
        input logic [DM_DATA_W-1:0] new_word,
        input logic [DM_DATA_W-1:0] wmask
    );
        return (old_word & ~wmask) | (new_word & wmask);
    endfunction

endpackage : dm_pkg

// File: rtl/dm_responder_if.sv
// -----------------------------------------------------------------------------
// dm_responder_if
// Access bus between a requester (master) and the data-memory responder (slave).
//   DM_c_en     chip enable, active-low (1 = no access)
//   DM_r_en     access type, 1 = read, 0 = write
//   DM_w_en     per-bit write enable, active-low
//   DM_addr     byte address, bits [1:0] ignored
//   DM_w_data   write data
//   DM_rd_data  registered read data
//   dm_ready    storage initialised and accepting accesses
//   dm_oob_err  sticky out-of-range access flag
// -----------------------------------------------------------------------------
interface dm_responder_if;
    import dm_pkg::*;

    logic                 DM_c_en;
    logic                 DM_r_en;
    logic [DM_DATA_W-1:0] DM_w_en;
    logic [31:0]          DM_addr;
    logic [DM_DATA_W-1:0] DM_w_data;
    logic [DM_DATA_W-1:0] DM_rd_data;
    logic                 dm_ready;
    logic                 dm_oob_err;

    modport master (
        output DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
        input  DM_rd_data, dm_ready, dm_oob_err
    );

    modport slave (
        input  DM_c_en, DM_r_en, DM_w_en, DM_addr, DM_w_data,
        output DM_rd_data, dm_ready, dm_oob_err
    );

endinterface : dm_responder_if

// File: rtl/dm_sram_array.sv
// -----------------------------------------------------------------------------
// dm_sram_array
// Single-port word storage with a bit-masked write and a registered read.
// The read register only updates on an enabled read, so it holds its value
// through idle and write cycles.
//   clk    clock
//   en     port enable
//   we     1 = write, 0 = read (when en = 1)
//   wmask  per-bit write enable, active-high
//   addr   word index
//   wdata  write data
//   rdata  registered read data
// -----------------------------------------------------------------------------
module dm_sram_array
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [DM_DATA_W-1:0] wmask,
    input  logic [IDX_W-1:0]     addr,
    input  logic [DM_DATA_W-1:0] wdata,
    output logic [DM_DATA_W-1:0] rdata
);

    logic [DM_DATA_W-1:0] mem [DEPTH];
    logic [DM_DATA_W-1:0] rdata_q;

    // No reset on the array or its output register so the tools can map both
    // onto block RAM; the controller masks rdata until a valid read lands.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= dm_merge(mem[addr], wdata, wmask);
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule : dm_sram_array

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Data-memory responder. After reset release it zeroes every word of storage
// (CLEAR, one word per cycle), then accepts single-cycle reads and bit-masked
// writes (READY). Out-of-range accesses touch no storage, read back as zero
// and set a sticky error flag.
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-low reset
//   bus  dm_responder_if.slave access bus
// -----------------------------------------------------------------------------
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    dm_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0]       ST_CLEAR = CLEAR;
    localparam logic [0:0]       ST_READY = READY;
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             oob_err_q, oob_err_d;
    // 1 when the last accepted read was in range; otherwise the output reads 0
    logic             rd_ok_q,   rd_ok_d;

    logic                 ram_en;
    logic                 ram_we;
    logic [DM_DATA_W-1:0] ram_mask;
    logic [IDX_W-1:0]     ram_addr;
    logic [DM_DATA_W-1:0] ram_wdata;
    logic [DM_DATA_W-1:0] ram_rdata;

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_lsb;

    assign idx             = bus.DM_addr[IDX_W+1:2];
    assign in_range        = (bus.DM_addr[31:IDX_W+2] == '0);
    assign accept          = (state_q == ST_READY) && !bus.DM_c_en;
    assign unused_addr_lsb = ^bus.DM_addr[1:0];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        oob_err_d = oob_err_q;
        rd_ok_d   = rd_ok_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_mask  = '0;
        ram_addr  = idx;
        ram_wdata = bus.DM_w_data;

        case (state_q)
            ST_CLEAR: begin
                // The clear sweep owns the storage port; bus requests are dropped.
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_mask  = '1;
                ram_addr  = clr_cnt_q;
                ram_wdata = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            default: begin
                if (accept) begin
                    if (in_range) begin
                        ram_en   = 1'b1;
                        ram_we   = !bus.DM_r_en;
                        ram_mask = ~bus.DM_w_en;
                        if (bus.DM_r_en) begin
                            rd_ok_d = 1'b1;
                        end
                    end else begin
                        oob_err_d = 1'b1;
                        if (bus.DM_r_en) begin
                            rd_ok_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            oob_err_q <= 1'b0;
            rd_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            oob_err_q <= oob_err_d;
            rd_ok_q   <= rd_ok_d;
        end
    end

    dm_sram_array #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .wmask (ram_mask),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Both terms are registers, so the output changes only at a clock edge
    // (or at reset), and holds whenever no read is accepted.
    assign bus.DM_rd_data = rd_ok_q ? ram_rdata : '0;
    assign bus.dm_ready   = (state_q == ST_READY);
    assign bus.dm_oob_err = oob_err_q;

endmodule : dm_responder

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed self-checking bench for dm_responder with DEPTH = 16.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dm_responder_if bus_if ();

    dm_responder #(
        .DEPTH (DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus_if.DM_c_en   = 1'b1;
        bus_if.DM_r_en   = 1'b1;
        bus_if.DM_w_en   = '1;
        bus_if.DM_addr   = '0;
        bus_if.DM_w_data = '0;
    endtask

    task automatic idle_cycle();
        set_idle();
        tick();
    endtask

    task automatic rd(input logic [31:0] addr);
        bus_if.DM_c_en   = 1'b0;
        bus_if.DM_r_en   = 1'b1;
        bus_if.DM_w_en   = '1;
        bus_if.DM_addr   = addr;
        bus_if.DM_w_data = '0;
        tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] wen_n);
        bus_if.DM_c_en   = 1'b0;
        bus_if.DM_r_en   = 1'b0;
        bus_if.DM_w_en   = wen_n;
        bus_if.DM_addr   = addr;
        bus_if.DM_w_data = data;
        tick();
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic oob, input logic [31:0] rdd);
        check_val({tag, "_ready"}, {31'b0, bus_if.dm_ready}, {31'b0, rdy});
        check_val({tag, "_oob"},   {31'b0, bus_if.dm_oob_err}, {31'b0, oob});
        check_val({tag, "_rd"},    bus_if.DM_rd_data, rdd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        set_idle();

        // Reset state
        repeat (3) tick();
        check_status("reset", 1'b0, 1'b0, 32'h0);

        // Release: CLEAR lasts exactly DEPTH cycles
        rst = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check_val($sformatf("clear_ready_c%0d", i), {31'b0, bus_if.dm_ready}, (i == DEPTH) ? 32'd1 : 32'd0);
        end

        // Every word reads back zero, back-to-back
        for (int i = 0; i < DEPTH; i++) begin
            rd(32'(i * 4));
            check_val($sformatf("init_rd_idx%0d", i), bus_if.DM_rd_data, 32'h0);
        end

        // Full write then read
        wr(32'h8, 32'hDEADBEEF, 32'h0);
        check_val("rd_hold_on_write", bus_if.DM_rd_data, 32'h0);
        rd(32'h8);
        check_val("rd_after_write", bus_if.DM_rd_data, 32'hDEADBEEF);

        // Masked write keeps the upper half
        wr(32'h8, 32'h12345678, 32'hFFFF0000);
        rd(32'h8);
        check_val("masked_write", bus_if.DM_rd_data, 32'hDEAD5678);
        wr(32'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rd(32'h8);
        check_val("all_ones_wen_nochange", bus_if.DM_rd_data, 32'hDEAD5678);

        // Pipelined reads then hold
        wr(32'h0, 32'h11111111, 32'h0);
        wr(32'h4, 32'h22222222, 32'h0);
        wr(32'h3C, 32'hCAFEF00D, 32'h0);
        rd(32'h0);
        check_val("pipe_rd0", bus_if.DM_rd_data, 32'h11111111);
        rd(32'h4);
        check_val("pipe_rd1", bus_if.DM_rd_data, 32'h22222222);
        rd(32'h8);
        check_val("pipe_rd2", bus_if.DM_rd_data, 32'hDEAD5678);
        idle_cycle();
        check_val("pipe_hold_idle", bus_if.DM_rd_data, 32'hDEAD5678);
        rd(32'h3C);
        check_val("rd_last_idx", bus_if.DM_rd_data, 32'hCAFEF00D);
        check_val("oob_clear_before", {31'b0, bus_if.dm_oob_err}, 32'd0);

        // Out-of-range read and write
        rd(32'h40);
        check_val("oob_rd_data", bus_if.DM_rd_data, 32'h0);
        check_val("oob_rd_flag", {31'b0, bus_if.dm_oob_err}, 32'd1);
        wr(32'h48, 32'hAAAAAAAA, 32'h0);
        rd(32'h8);
        check_val("oob_wr_no_alias", bus_if.DM_rd_data, 32'hDEAD5678);
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                rd(32'h4);
                check_val($sformatf("sticky_rd%0d", k), bus_if.DM_rd_data, 32'h22222222);
            end else begin
                wr(32'h0, 32'(k), 32'h0);
            end
            check_val($sformatf("sticky_oob%0d", k), {31'b0, bus_if.dm_oob_err}, 32'd1);
        end
        rd(32'h0);
        check_val("last_wr_word0", bus_if.DM_rd_data, 32'd9);

        // Reset, run CLEAR to count 7, pulse reset, full CLEAR restarts
        rst = 1'b0;
        #2;
        check_status("rst_ready_state", 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        bus_if.DM_c_en = 1'b0;
        bus_if.DM_r_en = 1'b1;
        bus_if.DM_addr = 32'h40;
        repeat (7) tick();
        #2 rst = 1'b0;
        #1;
        check_status("rst_mid_clear", 1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            bus_if.DM_c_en = 1'b0;
            if (i % 2 == 1) begin
                bus_if.DM_r_en = 1'b1;
                bus_if.DM_addr = 32'h40;
            end else begin
                bus_if.DM_r_en   = 1'b0;
                bus_if.DM_addr   = 32'h3C;
                bus_if.DM_w_en   = 32'h0;
                bus_if.DM_w_data = 32'h55555555;
            end
            tick();
            check_val($sformatf("reclear_ready_c%0d", i), {31'b0, bus_if.dm_ready}, (i == DEPTH) ? 32'd1 : 32'd0);
        end
        check_val("reclear_oob", {31'b0, bus_if.dm_oob_err}, 32'd0);
        check_val("reclear_rd", bus_if.DM_rd_data, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(32'(i * 4));
            check_val($sformatf("reclear_rd_idx%0d", i), bus_if.DM_rd_data, 32'h0);
        end
        check_val("reclear_oob_end", {31'b0, bus_if.dm_oob_err}, 32'd0);

        set_idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dm_responder

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL take parameter DEPTH, default 1024, giving the number of 32-bit words of storage.
REQ-002 The block SHALL derive local constant IDX_W as clog2(DEPTH), giving the word-index width.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 DM_c_en  input  1  chip enable, active-low; 1 = no access.
REQ-006 DM_r_en  input  1  access type; 1 = read, 0 = write.
REQ-007 DM_w_en  input  32  per-bit write enable, active-low; bit k = 0 writes data bit k.
REQ-008 DM_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 DM_w_data  input  32  write data.
REQ-010 DM_rd_data  output  32  registered read data.
REQ-011 dm_ready  output  1  1 = storage initialised and accepting accesses.
REQ-012 dm_oob_err  output  1  sticky flag for out-of-range access.

Function
REQ-013 The word index SHALL be DM_addr[IDX_W+1:2]; an address is in range iff DM_addr[31:IDX_W+2] == 0.
REQ-014 An access SHALL be accepted in a cycle iff dm_ready = 1 and DM_c_en = 0; all other cycles SHALL leave storage and DM_rd_data unchanged.
REQ-015 Accepted in-range read: DM_rd_data SHALL equal mem[idx] exactly one cycle later (1-cycle latency).
REQ-016 Back-to-back reads SHALL be supported every cycle, each returning data one cycle after its request.
REQ-017 DM_rd_data SHALL hold its last value through idle and write cycles.
REQ-018 Accepted in-range write: mem[idx] SHALL become (mem[idx] AND DM_w_en) OR (DM_w_data AND NOT DM_w_en) at that edge.
REQ-019 A write with DM_w_en = all ones SHALL change no storage bit.
REQ-020 A read issued the cycle after a write to the same index SHALL return the updated word.
REQ-021 Accepted out-of-range access: no storage SHALL change, a read SHALL return 0 one cycle later, and dm_oob_err SHALL be set.
REQ-022 dm_oob_err SHALL remain 1 until reset.
REQ-023 FSM states SHALL be CLEAR and READY.
REQ-024 In CLEAR, an IDX_W-bit counter SHALL zero mem[counter] each cycle, counting 0 to DEPTH-1.
REQ-025 After writing index DEPTH-1, the FSM SHALL enter READY, making CLEAR last exactly DEPTH cycles after reset release.
REQ-026 dm_ready SHALL be 1 only in READY; READY SHALL persist until reset.
REQ-027 Accesses presented during CLEAR SHALL be ignored, and SHALL NOT set dm_oob_err.

Reset
REQ-028 While rst = 0, the block SHALL hold FSM = CLEAR, clear counter = 0, DM_rd_data = 0, dm_ready = 0 and dm_oob_err = 0.
REQ-029 Storage contents SHALL be undefined during reset and defined (zero) only after CLEAR completes.
REQ-030 A reset asserted mid-CLEAR or in READY SHALL abort activity and, on release, restart CLEAR from index 0.

Structure
REQ-031 DM_DEPTH default and the state enum {CLEAR, READY} SHALL live in shared package dm_pkg.
REQ-032 Storage SHALL be sub-module dm_sram_array with a single port, a bit-masked write and a registered read.
REQ-033 FSM, counter, range check and error flag SHALL reside in dm_responder.

Verification
REQ-034 Reset, then rst=1, DEPTH=16 -> dm_ready 0 for exactly 16 cycles, then 1; a read of every index returns 0.
REQ-035 In READY: write addr 0x8, data 0xDEADBEEF, w_en 0; next cycle read 0x8 -> DM_rd_data = 0xDEADBEEF one cycle later.
REQ-036 Word 0x8 = 0xDEADBEEF; write 0x12345678 with w_en 0xFFFF0000 -> read returns 0xDEAD5678; then a write with w_en all ones leaves it unchanged.
REQ-037 DEPTH=16: read addr 0x40 -> DM_rd_data = 0 next cycle, dm_oob_err = 1 and stays 1 through 10 further valid accesses.
REQ-038 Pulse rst low at clear count 7, then release -> a full 16-cycle CLEAR restarts, and accesses during it are ignored with dm_oob_err = 0.
REQ-039 Reads of 0x0, 0x4, 0x8 on consecutive cycles with DM_c_en = 0, followed by one cycle of DM_c_en = 1 -> three pipelined results in order, then DM_rd_data holds the 0x8 value.
